edge_event_unit: RTL and testbench
==================================

# edge_event_unit

Multi-channel input event detector: per channel, synchronises an asynchronous level, optionally debounces it, detects rising/falling/both edges under a run-time mode, and latches qualified edges into sticky pending flags with a masked interrupt. It is the generalised successor of the two-flop edge detector. It sits between external or slow-domain status lines and the control logic or interrupt aggregation.

## Interface
- WIDTH, 8, number of independent channels (≥1)
- SYNC_STAGES, 2, synchroniser flops per channel (≥2)
- FILTER_CYCLES, 4, consecutive stable cycles required before the filtered level changes (≥1; only used with debounce compiled in)
- clk  input  1  clock; all logic on rising edge
- sync_reset  input  1  synchronous, active-high reset
- signal_in  input  WIDTH  raw asynchronous channel levels
- mode  input  2*WIDTH  per channel, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- irq_mask  input  WIDTH  1 = channel may drive irq
- clear_valid  input  1  qualifies clear_mask this cycle
- clear_mask  input  WIDTH  1 = clear pending flag of that channel
- level_out  output  WIDTH  filtered (debounced) level
- edge_pulse  output  WIDTH  one-cycle pulse per qualified edge
- pending  output  WIDTH  sticky latched events
- irq  output  1  OR of (pending & irq_mask), registered

## Operation
- Reset: all synchroniser flops, filtered levels, filter counters, edge_pulse, pending, irq = 0. The filtered level starts at 0, so an input held high through reset produces a rising event after release, if the mode permits.
- Synchroniser: a SYNC_STAGES-deep shift chain per channel; sync level = last stage.
- Debounce filter, per channel, with counter width clog2(FILTER_CYCLES)+1:
  - sync == filtered: counter ← 0.
  - sync != filtered and counter == FILTER_CYCLES-1: filtered ← sync; counter ← 0.
  - Otherwise: counter ← counter+1.
  - A glitch shorter than FILTER_CYCLES cycles is discarded.
- Edge qualification: rise = filtered changes 0→1 this cycle; fall = 1→0. edge_pulse[i] ← (rise & mode bit0) | (fall & mode bit1). Mode 00 suppresses the pulse; level_out still tracks.
- Mode is sampled in the cycle the filtered level changes. Changing mode never generates events.
- Pending: pending[i] ← (pending[i] & ~(clear_valid & clear_mask[i])) | edge_pulse_next[i]. When a set and a clear hit the same channel in the same cycle, the set wins and the flag stays 1.
- irq ← |(pending_next & irq_mask). Masking does not clear pending.
- Channels are fully independent; simultaneous edges on any subset are all captured.
- sync_reset asserted mid-filter or mid-pulse: every state goes to reset values on that edge, and in-flight counts are discarded.

## Timing
- Input change sampled at clock edge k:
  - level_out and edge_pulse change after edge k+SYNC_STAGES+FILTER_CYCLES-1, i.e. a latency of SYNC_STAGES+FILTER_CYCLES edges.
  - pending and irq update on the same edge as edge_pulse.
- edge_pulse width: exactly 1 cycle.
- Minimum spacing between two events on one channel: FILTER_CYCLES cycles.
- Clear: pending falls on the edge after clear_valid is sampled; irq falls on the same edge.
- No handshake back-pressure; events are never lost, only merged into an already-set pending bit.

## Configuration
- Macro EDGE_EVENT_DEBOUNCE_EN.
  - Defined: the debounce filter is present as described above, and FILTER_CYCLES applies.
  - Undefined: the filter and its counters are removed and FILTER_CYCLES is ignored. Filtered level = sync level delayed one register, and edge latency = SYNC_STAGES+1 edges. All other behaviour is unchanged.

## Test plan
All cases use WIDTH=4, SYNC_STAGES=2, FILTER_CYCLES=3, debounce on unless noted.
- Reset release with signal_in=4'b0001, mode all 01 → level_out=0001, edge_pulse[0] one cycle at edge 5 after release, pending=0001, and with irq_mask=0001, irq=1.
- 2-cycle high glitch on ch1, mode=11 → no edge_pulse, pending unchanged; a 3-cycle high pulse on ch1 → rise then fall pulses, spaced 3 cycles apart.
- Ch2 mode=10 with a 0→1→0 input (each level held 5 cycles) → only the falling pulse; mode=00 → no pulse, but level_out[2] still toggles.
- pending=0100 with clear_valid=1, clear_mask=0100 in the same cycle as a new ch2 edge → pending stays 0100. A later clear alone → 0000 next cycle, and irq drops.
- Simultaneous rising edges on all 4 channels with irq_mask=1000 → edge_pulse=1111 for one cycle, pending=1111, irq=1. Clearing 1000 → irq=0 while pending=0111.
- EDGE_EVENT_DEBOUNCE_EN undefined: a 1-cycle input pulse → rise and fall pulses, rise pulse at edge 3 after sampling. Assert sync_reset mid-sequence → all outputs 0 on the next edge.

Source files
------------

// File: rtl/edge_event_unit.sv
// Multi-channel event detector: synchroniser, optional debounce, mode-qualified edge pulses,
// sticky pending flags and a masked irq. Define EDGE_EVENT_DEBOUNCE_EN to build in the debounce filter.
module edge_event_unit #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic               clk,
    input  logic               sync_reset,
    input  logic [WIDTH-1:0]   signal_in,
    input  logic [2*WIDTH-1:0] mode,
    input  logic [WIDTH-1:0]   irq_mask,
    input  logic               clear_valid,
    input  logic [WIDTH-1:0]   clear_mask,
    output logic [WIDTH-1:0]   level_out,
    output logic [WIDTH-1:0]   edge_pulse,
    output logic [WIDTH-1:0]   pending,
    output logic               irq
);

    if (WIDTH < 1 || SYNC_STAGES < 2 || FILTER_CYCLES < 1) begin : g_bad_params
        $error("edge_event_unit: WIDTH>=1, SYNC_STAGES>=2, FILTER_CYCLES>=1 required");
    end

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_level;
    logic [WIDTH-1:0] filt_q;
    logic [WIDTH-1:0] filt_next;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] edge_next;
    logic [WIDTH-1:0] pending_next;

    assign sync_level = sync_q[SYNC_STAGES-1];
    assign level_out  = filt_q;

    // NOTE: every register is written with <= so all flops sample pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= signal_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

`ifdef EDGE_EVENT_DEBOUNCE_EN
    localparam int CNT_W = $clog2(FILTER_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q    [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];

    // The filtered level only follows sync after FILTER_CYCLES consecutive disagreeing cycles.
    always_comb begin
        // NOTE: defaults first so every path assigns every bit and no latch is inferred.
        filt_next = filt_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (sync_level[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    filt_next[i] = sync_level[i];
                end else begin
                    cnt_next[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_reset) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_next[i];
            end
        end
    end
`else
    assign filt_next = sync_level;
`endif

    // Mode is looked at only when the filtered level actually moves, so mode writes alone never fire.
    always_comb begin
        rise_en = '0;
        fall_en = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rise_en[i] = mode[2*i];
            fall_en[i] = mode[2*i+1];
        end
        edge_next    = (filt_next & ~filt_q & rise_en) | (~filt_next & filt_q & fall_en);
        pending_next = (pending & ~(clear_mask & {WIDTH{clear_valid}})) | edge_next;
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            filt_q     <= '0;
            edge_pulse <= '0;
            pending    <= '0;
            irq        <= 1'b0;
        end else begin
            filt_q     <= filt_next;
            edge_pulse <= edge_next;
            pending    <= pending_next;
            irq        <= |(pending_next & irq_mask);
        end
    end

endmodule

// File: tb/tb_edge_event_unit.sv
// Directed self-checking bench for edge_event_unit (WIDTH=4, SYNC_STAGES=2, FILTER_CYCLES=3).
module tb_edge_event_unit;

`ifdef EDGE_EVENT_DEBOUNCE_EN
    localparam int LAT = 2 + 3;
`else
    localparam int LAT = 2 + 1;
`endif

    logic       clk = 1'b0;
    logic       sync_reset;
    logic [3:0] signal_in;
    logic [7:0] mode;
    logic [3:0] irq_mask;
    logic       clear_valid;
    logic [3:0] clear_mask;
    logic [3:0] level_out;
    logic [3:0] edge_pulse;
    logic [3:0] pending;
    logic       irq;

    int checks = 0;
    int errs   = 0;

    edge_event_unit #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_CYCLES(3)) dut (
        .clk         (clk),
        .sync_reset  (sync_reset),
        .signal_in   (signal_in),
        .mode        (mode),
        .irq_mask    (irq_mask),
        .clear_valid (clear_valid),
        .clear_mask  (clear_mask),
        .level_out   (level_out),
        .edge_pulse  (edge_pulse),
        .pending     (pending),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_all();
        clear_valid = 1'b1;
        clear_mask  = 4'b1111;
        step(1);
        clear_valid = 1'b0;
        clear_mask  = 4'b0000;
    endtask

    // Plays wave[t] onto one channel, one bit per clock, and records that channel's pulses and level moves.
    task automatic drive_watch(input int ch, input logic [31:0] wave, input int n,
                               output int idx1, output int idx2, output int npulse,
                               output int ntoggle, output logic [3:0] other);
        logic prev_lvl;
        idx1 = 0; idx2 = 0; npulse = 0; ntoggle = 0; other = 4'b0000;
        prev_lvl = level_out[ch];
        for (int t = 0; t < n; t++) begin
            signal_in[ch] = wave[t];
            step(1);
            if (edge_pulse[ch]) begin
                npulse++;
                if (npulse == 1) idx1 = t + 1;
                else if (npulse == 2) idx2 = t + 1;
            end
            other |= edge_pulse & ~(4'b0001 << ch);
            if (level_out[ch] != prev_lvl) ntoggle++;
            prev_lvl = level_out[ch];
        end
    endtask

    task automatic test_reset();
        sync_reset = 1'b1; signal_in = 4'b0001; mode = 8'h55; irq_mask = 4'b0001;
        clear_valid = 1'b0; clear_mask = 4'b0000;
        step(3);
        checks++; if (level_out !== 4'b0000) begin errs++; $display("FAIL rst_level: got %b want 0000", level_out); end
        checks++; if (edge_pulse !== 4'b0000) begin errs++; $display("FAIL rst_pulse: got %b want 0000", edge_pulse); end
        checks++; if (pending !== 4'b0000 || irq !== 1'b0) begin errs++; $display("FAIL rst_pending: got %b/%b want 0000/0", pending, irq); end
        sync_reset = 1'b0;
        step(LAT - 1);
        checks++; if (edge_pulse !== 4'b0000 || level_out !== 4'b0000) begin errs++; $display("FAIL rel_early: pulse %b level %b want 0000 0000", edge_pulse, level_out); end
        step(1);
        checks++; if (edge_pulse !== 4'b0001) begin errs++; $display("FAIL rel_pulse: got %b want 0001", edge_pulse); end
        checks++; if (level_out !== 4'b0001) begin errs++; $display("FAIL rel_level: got %b want 0001", level_out); end
        checks++; if (pending !== 4'b0001 || irq !== 1'b1) begin errs++; $display("FAIL rel_pending: got %b/%b want 0001/1", pending, irq); end
        step(1);
        checks++; if (edge_pulse !== 4'b0000 || pending !== 4'b0001) begin errs++; $display("FAIL rel_width: pulse %b pending %b want 0000 0001", edge_pulse, pending); end
    endtask

    task automatic test_glitch();
        int i1, i2, np, nt;
        logic [3:0] oth;
        mode = 8'hFF;
        clear_all();
        checks++; if (pending !== 4'b0000 || irq !== 1'b0) begin errs++; $display("FAIL clr_all: got %b/%b want 0000/0", pending, irq); end
`ifdef EDGE_EVENT_DEBOUNCE_EN
        drive_watch(1, 32'h3, 12, i1, i2, np, nt, oth);
        checks++; if (np !== 0 || nt !== 0) begin errs++; $display("FAIL glitch: pulses %0d toggles %0d want 0 0", np, nt); end
        checks++; if (pending !== 4'b0000) begin errs++; $display("FAIL glitch_pend: got %b want 0000", pending); end
`else
        drive_watch(1, 32'h1, 10, i1, i2, np, nt, oth);
        checks++; if (np !== 2 || i1 !== 3 || i2 !== 4) begin errs++; $display("FAIL nodeb_pulse: n %0d at %0d,%0d want 2 at 3,4", np, i1, i2); end
        clear_all();
`endif
        drive_watch(1, 32'h7, 14, i1, i2, np, nt, oth);
        checks++; if (np !== 2 || i1 !== LAT || i2 !== LAT + 3) begin errs++; $display("FAIL pulse3: n %0d at %0d,%0d want 2 at %0d,%0d", np, i1, i2, LAT, LAT + 3); end
        checks++; if (oth !== 4'b0000 || pending !== 4'b0010) begin errs++; $display("FAIL pulse3_pend: other %b pending %b want 0000 0010", oth, pending); end
    endtask

    task automatic test_mode();
        int i1, i2, np, nt;
        logic [3:0] oth;
        logic [3:0] seen;
        clear_all();
        mode = 8'h20;
        drive_watch(2, 32'h3E0, 20, i1, i2, np, nt, oth);
        checks++; if (np !== 1 || i1 !== 10 + LAT) begin errs++; $display("FAIL fall_only: n %0d at %0d want 1 at %0d", np, i1, 10 + LAT); end
        checks++; if (nt !== 2 || pending !== 4'b0100) begin errs++; $display("FAIL fall_only_pend: toggles %0d pending %b want 2 0100", nt, pending); end
        seen = 4'b0000;
        mode = 8'h30;
        for (int t = 0; t < 3; t++) begin
            step(1);
            seen |= edge_pulse;
        end
        mode = 8'h00;
        step(1);
        seen |= edge_pulse;
        checks++; if (seen !== 4'b0000) begin errs++; $display("FAIL mode_change: got %b want 0000", seen); end
        drive_watch(2, 32'h3E0, 20, i1, i2, np, nt, oth);
        checks++; if (np !== 0 || nt !== 2) begin errs++; $display("FAIL mode_off: pulses %0d toggles %0d want 0 2", np, nt); end
        checks++; if (pending !== 4'b0100) begin errs++; $display("FAIL mode_off_pend: got %b want 0100", pending); end
    endtask

    task automatic test_set_clear();
        clear_all();
        mode = 8'h30; irq_mask = 4'b0100;
        signal_in[2] = 1'b1;
        step(LAT);
        checks++; if (edge_pulse !== 4'b0100 || pending !== 4'b0100 || irq !== 1'b1) begin errs++; $display("FAIL sc_rise: pulse %b pending %b irq %b want 0100 0100 1", edge_pulse, pending, irq); end
        step(3);
        signal_in[2] = 1'b0;
        step(LAT - 1);
        clear_valid = 1'b1; clear_mask = 4'b0100;
        step(1);
        clear_valid = 1'b0; clear_mask = 4'b0000;
        checks++; if (edge_pulse !== 4'b0100) begin errs++; $display("FAIL sc_fall: got %b want 0100", edge_pulse); end
        checks++; if (pending !== 4'b0100 || irq !== 1'b1) begin errs++; $display("FAIL set_wins: pending %b irq %b want 0100 1", pending, irq); end
        step(1);
        clear_valid = 1'b1; clear_mask = 4'b0100;
        step(1);
        clear_valid = 1'b0; clear_mask = 4'b0000;
        checks++; if (pending !== 4'b0000 || irq !== 1'b0) begin errs++; $display("FAIL clr_alone: pending %b irq %b want 0000 0", pending, irq); end
    endtask

    task automatic test_simultaneous();
        mode = 8'h55; signal_in = 4'b0000;
        step(LAT + 2);
        clear_all();
        irq_mask = 4'b1000;
        signal_in = 4'b1111;
        step(LAT - 1);
        checks++; if (edge_pulse !== 4'b0000 || irq !== 1'b0) begin errs++; $display("FAIL sim_early: pulse %b irq %b want 0000 0", edge_pulse, irq); end
        step(1);
        checks++; if (edge_pulse !== 4'b1111) begin errs++; $display("FAIL sim_pulse: got %b want 1111", edge_pulse); end
        checks++; if (pending !== 4'b1111 || irq !== 1'b1) begin errs++; $display("FAIL sim_pend: pending %b irq %b want 1111 1", pending, irq); end
        step(1);
        checks++; if (edge_pulse !== 4'b0000) begin errs++; $display("FAIL sim_width: got %b want 0000", edge_pulse); end
        clear_valid = 1'b1; clear_mask = 4'b1000;
        step(1);
        clear_valid = 1'b0; clear_mask = 4'b0000;
        checks++; if (pending !== 4'b0111 || irq !== 1'b0) begin errs++; $display("FAIL sim_clr: pending %b irq %b want 0111 0", pending, irq); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] seen;
        mode = 8'hFF; irq_mask = 4'b1111;
        signal_in = 4'b0000;
        step(2);
        sync_reset = 1'b1;
        step(1);
        checks++; if (level_out !== 4'b0000 || edge_pulse !== 4'b0000) begin errs++; $display("FAIL mid_rst_lvl: level %b pulse %b want 0000 0000", level_out, edge_pulse); end
        checks++; if (pending !== 4'b0000 || irq !== 1'b0) begin errs++; $display("FAIL mid_rst_pend: pending %b irq %b want 0000 0", pending, irq); end
        sync_reset = 1'b0;
        seen = 4'b0000;
        for (int t = 0; t < LAT + 2; t++) begin
            step(1);
            seen |= edge_pulse | pending;
        end
        checks++; if (seen !== 4'b0000) begin errs++; $display("FAIL mid_rst_after: got %b want 0000", seen); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_mode();
        test_set_clear();
        test_simultaneous();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end

endmodule
